// File: rtl/voter_record_store_if.sv
// ============================================================================
// voter_record_store_if : ID-database write strobes, officer read/clear port
// and status outputs of voter_record_store. Adds parity_error when
// VOTER_STORE_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface voter_record_store_if #(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 4
);
  logic              write;
  logic [ADDR_W-1:0] valid_voter_address;
  logic [ID_W-1:0]   valid_voter;
  logic              clear;
  logic              read_enable;
  logic [ADDR_W-1:0] read_address;
  logic              busy;
  logic              record_ack;
  logic              duplicate;
  logic              slot_conflict;
  logic [ID_W-1:0]   read_data;
  logic              read_valid;
  logic [ADDR_W:0]   stored_count;
  logic              full;
`ifdef VOTER_STORE_PARITY_EN
  logic              parity_error;
`endif

  modport master (
    output write, valid_voter_address, valid_voter, clear, read_enable, read_address,
    input  busy, record_ack, duplicate, slot_conflict, read_data, read_valid,
           stored_count, full
`ifdef VOTER_STORE_PARITY_EN
    , input parity_error
`endif
  );

  modport slave (
    input  write, valid_voter_address, valid_voter, clear, read_enable, read_address,
    output busy, record_ack, duplicate, slot_conflict, read_data, read_valid,
           stored_count, full
`ifdef VOTER_STORE_PARITY_EN
    , output parity_error
`endif
  );
endinterface

`default_nettype wire

// File: rtl/voter_record_store.sv
// ============================================================================
// voter_record_store : DEPTH-entry voter record with repeat-voter scan,
// slot-conflict detection, officer read port and clear.
// Optional feature macro: VOTER_STORE_PARITY_EN (per-entry even parity).
// Revision: 1.0
// ============================================================================
`default_nettype none

module voter_record_store #(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input wire                  clk,
  input wire                  reset_n,
  voter_record_store_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, REPORT} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_ACK, RES_DUP, RES_CONF} result_t;

  state_t            state, state_nx;
  result_t           result, result_nx;
  logic [ADDR_W-1:0] tgt_addr, tgt_addr_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [ID_W-1:0]   tgt_id, tgt_id_nx;
  logic              commit_en;
  logic              scan_hit;

  logic [ID_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]  occupied;
  logic [ADDR_W:0]   count;
  logic [ID_W-1:0]   rd_data;
  logic              rd_valid;

`ifdef VOTER_STORE_PARITY_EN
  logic              par [DEPTH];
  logic              perr;

  // An entry with corrupted parity is treated as unmatched during SCAN.
  always_comb scan_hit = occupied[idx] && (mem[idx] == tgt_id) && ((^mem[idx]) == par[idx]);
`else
  always_comb scan_hit = occupied[idx] && (mem[idx] == tgt_id);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      result   <= RES_NONE;
      tgt_addr <= '0;
      tgt_id   <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nx;
      result   <= result_nx;
      tgt_addr <= tgt_addr_nx;
      tgt_id   <= tgt_id_nx;
      idx      <= idx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    result_nx   = result;
    tgt_addr_nx = tgt_addr;
    tgt_id_nx   = tgt_id;
    idx_nx      = idx;
    commit_en   = 1'b0;
    if (bus.clear) begin
      state_nx  = IDLE;
      result_nx = RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write) begin
            tgt_addr_nx = bus.valid_voter_address;
            tgt_id_nx   = bus.valid_voter;
            idx_nx      = '0;
            result_nx   = RES_NONE;
            state_nx    = SCAN;
          end
        end
        SCAN: begin
          if (scan_hit) begin
            result_nx = RES_DUP;
            state_nx  = REPORT;
          end else if (idx == ADDR_W'(DEPTH - 1)) begin
            state_nx = COMMIT;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
        COMMIT: begin
          if (occupied[tgt_addr]) begin
            result_nx = RES_CONF;
          end else begin
            result_nx = RES_ACK;
            commit_en = 1'b1;
          end
          state_nx = REPORT;
        end
        REPORT: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupied <= '0;
      count    <= '0;
    end else if (bus.clear) begin
      occupied <= '0;
      count    <= '0;
    end else if (commit_en) begin
      occupied[tgt_addr] <= 1'b1;
      count              <= count + 1'b1;
    end
  end

  // Entry payloads need no reset: the occupied bits gate every use.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      mem[tgt_addr] <= tgt_id;
`ifdef VOTER_STORE_PARITY_EN
      par[tgt_addr] <= ^tgt_id;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef VOTER_STORE_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      rd_valid <= bus.read_enable;
      if (bus.read_enable) begin
        rd_data <= occupied[bus.read_address] ? mem[bus.read_address] : '0;
      end
`ifdef VOTER_STORE_PARITY_EN
      perr <= bus.read_enable && occupied[bus.read_address] &&
              ((^mem[bus.read_address]) != par[bus.read_address]);
`endif
    end
  end

  assign bus.busy          = (state == SCAN) || (state == COMMIT);
  assign bus.record_ack    = (state == REPORT) && (result == RES_ACK);
  assign bus.duplicate     = (state == REPORT) && (result == RES_DUP);
  assign bus.slot_conflict = (state == REPORT) && (result == RES_CONF);
  assign bus.read_data     = rd_data;
  assign bus.read_valid    = rd_valid;
  assign bus.stored_count  = count;
  assign bus.full          = (count == (ADDR_W + 1)'(DEPTH));
`ifdef VOTER_STORE_PARITY_EN
  assign bus.parity_error  = perr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_voter_record_store.sv
// ============================================================================
// tb_voter_record_store : directed self-checking bench for voter_record_store.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_voter_record_store;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  voter_record_store_if #(.ID_W(5), .ADDR_W(4)) bus ();

  voter_record_store #(.ID_W(5), .ADDR_W(4), .DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one write and wait for its result; returns to IDLE before exit.
  // kind: 0 none within budget, 1 ack, 2 duplicate, 3 slot_conflict
  task automatic do_write(input logic [3:0] a, input logic [4:0] id,
                          output int lat, output int kind, output int npulse);
    bus.write = 1'b1;
    bus.valid_voter_address = a;
    bus.valid_voter = id;
    @(posedge clk); #1;
    bus.write = 1'b0;
    lat = 0; kind = 0; npulse = 0;
    for (int n = 1; n <= 40; n++) begin
      npulse = int'(bus.record_ack) + int'(bus.duplicate) + int'(bus.slot_conflict);
      if (npulse != 0) begin
        lat  = n;
        kind = bus.record_ack ? 1 : (bus.duplicate ? 2 : 3);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [4:0] d, output logic v);
    bus.read_enable = 1'b1;
    bus.read_address = a;
    @(posedge clk); #1;
    bus.read_enable = 1'b0;
    d = bus.read_data;
    v = bus.read_valid;
  endtask

  task automatic test_reset;
    logic [4:0] d; logic v;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy, bus.record_ack, bus.duplicate, bus.slot_conflict, bus.full, bus.read_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000000",
        {bus.busy, bus.record_ack, bus.duplicate, bus.slot_conflict, bus.full, bus.read_valid});
    end
    n_checks++;
    if (bus.stored_count !== 5'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.stored_count);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_read(4'd5, d, v);
    n_checks++;
    if (d !== 5'd0 || v !== 1'b1) begin
      n_fail++; $display("FAIL reset_read: got data=%b valid=%b expected 00000/1", d, v);
    end
  endtask

  task automatic test_new_voter;
    int lat, kind, np; logic [4:0] d; logic v;
    do_write(4'd3, 5'b00010, lat, kind, np);
    n_checks++;
    if (kind != 1 || lat != 18 || np != 1) begin
      n_fail++; $display("FAIL new_voter_ack: got kind=%0d lat=%0d pulses=%0d expected 1/18/1", kind, lat, np);
    end
    n_checks++;
    if (bus.stored_count !== 5'd1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL new_voter_count: got count=%0d busy=%b expected 1/0", bus.stored_count, bus.busy);
    end
    do_read(4'd3, d, v);
    n_checks++;
    if (d !== 5'b00010 || v !== 1'b1) begin
      n_fail++; $display("FAIL new_voter_read: got data=%b valid=%b expected 00010/1", d, v);
    end
  endtask

  task automatic test_duplicate;
    int lat, kind, np; logic [4:0] d; logic v;
    do_write(4'd7, 5'b00010, lat, kind, np);
    n_checks++;
    if (kind != 2 || lat != 5) begin
      n_fail++; $display("FAIL duplicate_pulse: got kind=%0d lat=%0d expected 2/5", kind, lat);
    end
    do_read(4'd7, d, v);
    n_checks++;
    if (d !== 5'd0 || bus.stored_count !== 5'd1) begin
      n_fail++; $display("FAIL duplicate_nowrite: got entry7=%b count=%0d expected 00000/1", d, bus.stored_count);
    end
  endtask

  task automatic test_slot_conflict;
    int lat, kind, np; logic [4:0] d; logic v;
    do_write(4'd3, 5'b11000, lat, kind, np);
    n_checks++;
    if (kind != 3 || lat != 18) begin
      n_fail++; $display("FAIL conflict_pulse: got kind=%0d lat=%0d expected 3/18", kind, lat);
    end
    do_read(4'd3, d, v);
    n_checks++;
    if (d !== 5'b00010 || bus.stored_count !== 5'd1) begin
      n_fail++; $display("FAIL conflict_nowrite: got entry3=%b count=%0d expected 00010/1", d, bus.stored_count);
    end
  endtask

  // Writes offered mid-SCAN and during REPORT must both be dropped.
  task automatic test_back_to_back;
    int lat; logic [4:0] d; logic v;
    lat = 0;
    bus.write = 1'b1; bus.valid_voter_address = 4'd5; bus.valid_voter = 5'd7;
    @(posedge clk); #1;
    bus.write = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 4) begin
        bus.write = 1'b1; bus.valid_voter_address = 4'd6; bus.valid_voter = 5'd8;
      end
      if (n == 5) bus.write = 1'b0;
      if (bus.record_ack || bus.duplicate || bus.slot_conflict) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (lat != 18) begin
      n_fail++; $display("FAIL b2b_latency: got %0d expected 18", lat);
    end
    bus.write = 1'b1; bus.valid_voter_address = 4'd6; bus.valid_voter = 5'd9;
    @(posedge clk); #1;
    bus.write = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_report_write: got busy=%b expected 0", bus.busy);
    end
    do_read(4'd6, d, v);
    n_checks++;
    if (d !== 5'd0 || bus.stored_count !== 5'd2) begin
      n_fail++; $display("FAIL b2b_dropped: got entry6=%b count=%0d expected 00000/2", d, bus.stored_count);
    end
  endtask

  task automatic test_fill;
    int lat, kind, np, bad; logic [4:0] d; logic v;
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      if (a != 3 && a != 5) begin
        do_write(4'(a), 5'(a + 16), lat, kind, np);
        if (kind != 1 || lat != 18) bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL fill_acks: got %0d bad results expected 0", bad);
    end
    n_checks++;
    if (bus.stored_count !== 5'd16 || bus.full !== 1'b1) begin
      n_fail++; $display("FAIL fill_full: got count=%0d full=%b expected 16/1", bus.stored_count, bus.full);
    end
    do_write(4'd0, 5'd1, lat, kind, np);
    n_checks++;
    if (kind != 3 || lat != 18) begin
      n_fail++; $display("FAIL full_conflict: got kind=%0d lat=%0d expected 3/18", kind, lat);
    end
    do_read(4'd0, d, v);
    n_checks++;
    if (d !== 5'd16 || bus.stored_count !== 5'd16) begin
      n_fail++; $display("FAIL full_nowrite: got entry0=%0d count=%0d expected 16/16", d, bus.stored_count);
    end
    do_write(4'd0, 5'd25, lat, kind, np);
    n_checks++;
    if (kind != 2 || lat != 11) begin
      n_fail++; $display("FAIL dup_entry9: got kind=%0d lat=%0d expected 2/11", kind, lat);
    end
    do_write(4'd0, 5'd31, lat, kind, np);
    n_checks++;
    if (kind != 2 || lat != 17) begin
      n_fail++; $display("FAIL dup_last_entry: got kind=%0d lat=%0d expected 2/17", kind, lat);
    end
  endtask

  task automatic test_clear;
    int pulses, lat, kind, np; logic [4:0] d; logic v;
    pulses = 0;
    bus.write = 1'b1; bus.valid_voter_address = 4'd2; bus.valid_voter = 5'd3;
    @(posedge clk); #1;
    bus.write = 1'b0;
    for (int n = 1; n < 8; n++) begin
      @(posedge clk); #1;
    end
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.stored_count !== 5'd0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL clear_abort: got busy=%b count=%0d full=%b expected 0/0/0",
        bus.busy, bus.stored_count, bus.full);
    end
    for (int n = 0; n < 25; n++) begin
      if (bus.record_ack || bus.duplicate || bus.slot_conflict) pulses++;
      @(posedge clk); #1;
    end
    bus.clear = 1'b1;
    bus.write = 1'b1; bus.valid_voter_address = 4'd4; bus.valid_voter = 5'd10;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.write = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_with_write: got busy=%b expected 0", bus.busy);
    end
    for (int n = 0; n < 22; n++) begin
      if (bus.record_ack || bus.duplicate || bus.slot_conflict) pulses++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL clear_no_result: got %0d pulses expected 0", pulses);
    end
    do_read(4'd4, d, v);
    n_checks++;
    if (d !== 5'd0) begin
      n_fail++; $display("FAIL clear_entry4: got %b expected 00000", d);
    end
    do_write(4'd3, 5'b00010, lat, kind, np);
    n_checks++;
    if (kind != 1 || lat != 18 || bus.stored_count !== 5'd1) begin
      n_fail++; $display("FAIL clear_rewrite: got kind=%0d lat=%0d count=%0d expected 1/18/1",
        kind, lat, bus.stored_count);
    end
  endtask

`ifdef VOTER_STORE_PARITY_EN
  task automatic test_parity;
    logic [4:0] d; logic v; logic pe;
    do_read(4'd3, d, v);
    pe = bus.parity_error;
    n_checks++;
    if (pe !== 1'b0) begin
      n_fail++; $display("FAIL parity_clean: got %b expected 0", pe);
    end
    dut.mem[3] = dut.mem[3] ^ 5'b00001;
    do_read(4'd3, d, v);
    pe = bus.parity_error;
    n_checks++;
    if (pe !== 1'b1 || v !== 1'b1) begin
      n_fail++; $display("FAIL parity_flip: got err=%b valid=%b expected 1/1", pe, v);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus.write = 1'b0;
    bus.valid_voter_address = '0;
    bus.valid_voter = '0;
    bus.clear = 1'b0;
    bus.read_enable = 1'b0;
    bus.read_address = '0;
    test_reset();
    test_new_voter();
    test_duplicate();
    test_slot_conflict();
    test_back_to_back();
    test_fill();
    test_clear();
`ifdef VOTER_STORE_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
